// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters decoded into registered sync, DE and pixel coordinates.
// Optional start-of-frame strobe O_sof is enabled by defining VIDEO_TIMING_GEN_SOF_EN.
module video_timing_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        I_pxl_clk,
    input  logic        I_rst,
    output logic        O_hs,
    output logic        O_vs,
    output logic        O_de,
    output logic [11:0] O_x,
    output logic [11:0] O_y
`ifdef VIDEO_TIMING_GEN_SOF_EN
    ,
    output logic        O_sof
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        sof_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 12'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
        end

        // Outputs decode the counters as they stand now, so they lag the counters by one edge.
        de_d  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_d  = ((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END)) ? HS_POL : ~HS_POL;
        vs_d  = ((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END)) ? VS_POL : ~VS_POL;
        x_d   = de_d ? h_cnt_q : 12'd0;
        y_d   = de_d ? v_cnt_q : 12'd0;
        sof_d = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    end

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            x_q     <= 12'd0;
            y_q     <= 12'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign O_hs = hs_q;
    assign O_vs = vs_q;
    assign O_de = de_q;
    assign O_x  = x_q;
    assign O_y  = y_q;

`ifdef VIDEO_TIMING_GEN_SOF_EN
    logic sof_q;

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            sof_q <= 1'b0;
        end else begin
            sof_q <= sof_d;
        end
    end

    assign O_sof = sof_q;
`else
    logic unused_sof;
    assign unused_sof = sof_d;
`endif

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280: active pixels per line.
REQ-002 SHALL have parameter H_FP, default 110: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 40: hsync width, in pixels.
REQ-004 SHALL have parameter H_BP, default 220: horizontal back porch, in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 720: active lines per frame.
REQ-006 SHALL have parameter V_FP, default 5: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 5: vsync width, in lines.
REQ-008 SHALL have parameter V_BP, default 20: vertical back porch, in lines.
REQ-009 SHALL have parameter HS_POL, default 1: hsync active level (1 = active-high).
REQ-010 SHALL have parameter VS_POL, default 1: vsync active level (1 = active-high).
REQ-011 SHALL have port I_pxl_clk, input, width 1: pixel clock (74.25 MHz for 720p60); only clock.
REQ-012 SHALL have port I_rst, input, width 1: reset, synchronous, active-high.
REQ-013 SHALL have port O_hs, output, width 1: horizontal sync.
REQ-014 SHALL have port O_vs, output, width 1: vertical sync; end-of-frame marker for the pattern stage.
REQ-015 SHALL have port O_de, output, width 1: data enable, high during the active region.
REQ-016 SHALL have port O_x, output, width 12: pixel column, aligned with O_de.
REQ-017 SHALL have port O_y, output, width 12: line number, aligned with O_de.

Function
REQ-018 SHALL keep h_cnt in the range 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650 by default).
REQ-019 SHALL keep v_cnt in the range 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750 by default).
REQ-020 SHALL increment h_cnt every cycle; at H_TOTAL-1 it wraps to 0 and v_cnt advances in the same cycle.
REQ-021 SHALL wrap v_cnt to 0 when it advances from V_TOTAL-1, so h and v wrap in the same cycle.
REQ-022 SHALL order regions within each line as active, FP, sync, BP: active is h_cnt < H_ACTIVE; sync is H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (1390..1429 by default).
REQ-023 SHALL order vertical regions the same way: active is v_cnt < V_ACTIVE; sync is 725..729 by default.
REQ-024 SHALL register every output from the counter state, giving 1-cycle latency: the outputs at edge n+1 decode the counters held at edge n.
REQ-025 SHALL drive O_de = (h_cnt < H_ACTIVE) AND (v_cnt < V_ACTIVE).
REQ-026 SHALL drive O_hs = HS_POL inside the h-sync region and ~HS_POL elsewhere.
REQ-027 SHALL drive O_vs = VS_POL for every cycle of the lines in the v-sync region and ~VS_POL elsewhere; O_vs edges coincide with the line wrap.
REQ-028 SHALL drive O_x = h_cnt and O_y = v_cnt when O_de = 1, and hold both at 0 when O_de = 0.
REQ-029 SHALL be correct for any parameter set with every parameter >= 1 and H_TOTAL, V_TOTAL <= 4096.

Reset
REQ-030 SHALL, on any edge with I_rst = 1, set h_cnt = 0, v_cnt = 0, O_de = 0, O_x = 0, O_y = 0, O_hs = ~HS_POL, O_vs = ~VS_POL.
REQ-031 SHALL, at the first edge with I_rst = 0, register the decode of (0,0), giving O_de = 1 and O_x = O_y = 0, and advance h_cnt to 1.
REQ-032 SHALL treat a reset asserted mid-frame exactly as in REQ-030, with no partial line or frame retained.

Configuration
REQ-033 SHALL, when macro VIDEO_TIMING_GEN_SOF_EN is defined, add output O_sof (width 1), registered and asserted for exactly the one cycle where O_de = 1, O_x = 0 and O_y = 0; O_sof is 0 in reset.
REQ-034 SHALL, without VIDEO_TIMING_GEN_SOF_EN, omit O_sof and its logic and leave all other behaviour identical.

Verification
REQ-035 SHALL cover: reset for 4 cycles, then release -> first cycle after release has O_de = 1, O_x = 0; O_de then stays high 1280 cycles and low 370 cycles per line, and O_x reaches 1279.
REQ-036 SHALL cover: per-line O_hs timing -> O_hs rises 1390 cycles after O_de rises, stays high 40 cycles, and has a 1650-cycle period.
REQ-037 SHALL cover: per-frame O_vs timing -> O_vs high 8250 cycles, rising 1,196,250 cycles after frame start, with a 1,237,500-cycle frame period; O_y spans 0..719.
REQ-038 SHALL cover: I_rst pulsed 1 cycle at O_y = 300, O_x = 500 -> next edge all outputs at reset values; following edge O_de = 1, O_x = O_y = 0.
REQ-039 SHALL cover: parameters H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=V_SYNC=V_BP=1 -> 8-cycle lines, 6-line frames, and correct wrap of both counters in the same cycle.
REQ-040 SHALL cover: with VIDEO_TIMING_GEN_SOF_EN defined, run 3 frames -> O_sof high exactly 3 times, 1,237,500 cycles apart, each coincident with O_x = O_y = 0.
